// File: rtl/gate_test_sequencer.sv
// Self-checking stimulus controller for a 2-input gate: walks the four input
// vectors, waits a settle interval, samples the gate and scores it against EXPECT.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 7,
  parameter logic [3:0]  EXPECT        = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       gate_in1,
  output logic       gate_in2,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_idx_q, vec_idx_d;
  logic       gate_in1_q, gate_in1_d;
  logic       gate_in2_q, gate_in2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_mask_q, fail_mask_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_idx_d   = vec_idx_q;
    gate_in1_d  = gate_in1_q;
    gate_in2_d  = gate_in2_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_APPLY;
          vec_idx_d   = 2'd0;
          gate_in1_d  = 1'b0;
          gate_in2_d  = 1'b0;
          fail_mask_d = 4'b0000;
          pass_d      = 1'b0;
        end
      end
      S_APPLY: begin
        cnt_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (gate_out != EXPECT[vec_idx_q]) begin
          fail_mask_d[vec_idx_q] = 1'b1;
        end
        if (vec_idx_q == 2'd3) begin
          // pass is decided here so it already reflects the final sample in DONE
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_mask_d == 4'b0000);
        end else begin
          vec_idx_d                = vec_idx_q + 2'd1;
          {gate_in1_d, gate_in2_d} = vec_idx_d;
          state_d                  = S_APPLY;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        vec_idx_d  = 2'd0;
        gate_in1_d = 1'b0;
        gate_in2_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      vec_idx_q   <= 2'd0;
      gate_in1_q  <= 1'b0;
      gate_in2_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_idx_q   <= vec_idx_d;
      gate_in1_q  <= gate_in1_d;
      gate_in2_q  <= gate_in2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign gate_in1  = gate_in1_q;
  assign gate_in2  = gate_in2_q;
  assign vec_idx   = vec_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: a default instance and a SETTLE_CYCLES=1/XOR
// instance, driven by directed and randomized gate models.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic       glitch_on, glitch_val;
  logic [3:0] gtab;
  int         sel;
  int         n_checks;
  int         n_pass;

  logic       a_in1, a_in2, a_busy, a_done, a_pass, a_gout;
  logic [1:0] a_vec;
  logic [3:0] a_mask;
  logic       b_in1, b_in2, b_busy, b_done, b_pass, b_gout;
  logic [1:0] b_vec;
  logic [3:0] b_mask;

  // Behavioural gate: truth table gtab, optionally replaced by noise while settling
  assign a_gout = glitch_on ? glitch_val : gtab[{a_in1, a_in2}];
  assign b_gout = glitch_on ? glitch_val : gtab[{b_in1, b_in2}];

  gate_test_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .gate_out(a_gout),
    .gate_in1(a_in1), .gate_in2(a_in2), .vec_idx(a_vec), .busy(a_busy),
    .done(a_done), .pass(a_pass), .fail_mask(a_mask)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXPECT(4'b0110)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .gate_out(b_gout),
    .gate_in1(b_in1), .gate_in2(b_in2), .vec_idx(b_vec), .busy(b_busy),
    .done(b_done), .pass(b_pass), .fail_mask(b_mask)
  );

  logic       o_in1, o_in2, o_busy, o_done, o_pass;
  logic [1:0] o_vec;
  logic [3:0] o_mask;
  assign o_in1  = (sel == 1) ? b_in1  : a_in1;
  assign o_in2  = (sel == 1) ? b_in2  : a_in2;
  assign o_busy = (sel == 1) ? b_busy : a_busy;
  assign o_done = (sel == 1) ? b_done : a_done;
  assign o_pass = (sel == 1) ? b_pass : a_pass;
  assign o_vec  = (sel == 1) ? b_vec  : a_vec;
  assign o_mask = (sel == 1) ? b_mask : a_mask;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) start_b = v;
    else start_a = v;
  endtask

  // Full status word: {busy,done,vec,in1,in2,pass,mask}
  function automatic logic [31:0] status();
    return {21'd0, o_busy, o_done, o_vec, o_in1, o_in2, o_pass, o_mask};
  endfunction

  function automatic logic [31:0] mk(input logic bsy, input logic dn, input logic [1:0] v,
                                     input logic ps, input logic [3:0] m);
    return {21'd0, bsy, dn, v, v[1], v[0], ps, m};
  endfunction

  // One complete run from IDLE. Expected behaviour comes from the timeline
  // arithmetic: vector v occupies edges v*P .. v*P+P-1 with P = s+2, done at 4P.
  task automatic do_run(input string tag, input int s, input logic [3:0] expt,
                        input bit glitch, input bit repulse, input bit keep_start);
    int         p;
    int         ph;
    logic [3:0] emask;
    logic [1:0] v;
    logic       ok;
    p = s + 2;
    for (int i = 0; i < 4; i++) emask[i] = (gtab[i] != expt[i]);
    set_start(1'b1);
    tick();
    if (!keep_start) set_start(1'b0);
    check({tag, ":edge0"}, status(), mk(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000));
    ok = 1'b1;
    for (int k = 1; k <= 4 * p; k++) begin
      ph = (k - 1) % p;
      if (!keep_start) set_start(repulse && (k - 1 == p + 2));
      glitch_on  = glitch && (ph >= 1) && (ph <= s);
      glitch_val = 1'($urandom);
      tick();
      v = (k < 4 * p) ? 2'(k / p) : 2'd3;
      if ({o_busy, o_done, o_vec, o_in1, o_in2} !== {1'b1, (k == 4 * p), v, v}) begin
        check({tag, ":timeline"}, {o_busy, o_done, o_vec, o_in1, o_in2},
              {1'b1, (k == 4 * p), v, v});
        ok = 1'b0;
      end
    end
    glitch_on = 1'b0;
    check({tag, ":timeline_ok"}, 32'(ok), 32'd1);
    check({tag, ":done_result"}, status(), mk(1'b1, 1'b1, 2'd3, (emask == 4'b0000), emask));
    if (repulse || keep_start) set_start(1'b1);
    tick();
    if (!keep_start) set_start(1'b0);
    check({tag, ":idle_after"}, status(), mk(1'b0, 1'b0, 2'd0, (emask == 4'b0000), emask));
    tick();
    if (keep_start) begin
      set_start(1'b0);
      check({tag, ":retrigger"}, status(), mk(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000));
    end else begin
      check({tag, ":stay_idle"}, status(), mk(1'b0, 1'b0, 2'd0, (emask == 4'b0000), emask));
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    sel        = 0;
    rst_n      = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    glitch_on  = 1'b0;
    glitch_val = 1'b0;
    gtab       = 4'b1110;
    tick();
    tick();
    check("reset_a", status(), 32'd0);
    sel = 1;
    check("reset_b", status(), 32'd0);
    sel = 0;
    rst_n = 1'b1;
    tick();
    check("idle_no_start", status(), 32'd0);

    // Ideal OR, stuck-at-0, AND against the default OR table
    gtab = 4'b1110;
    do_run("or", 7, 4'b1110, 1'b0, 1'b0, 1'b0);
    gtab = 4'b0000;
    do_run("stuck0", 7, 4'b1110, 1'b0, 1'b0, 1'b0);
    gtab = 4'b1000;
    do_run("and", 7, 4'b1110, 1'b0, 1'b0, 1'b0);

    // start re-pulsed in SETTLE of vector 1 and in the DONE cycle
    gtab = 4'b1110;
    do_run("repulse", 7, 4'b1110, 1'b0, 1'b1, 1'b0);

    // Reset during SETTLE of vector 2, after vector 1 already recorded a mismatch
    gtab = 4'b0000;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    repeat (2 * 9 + 3) tick();
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    check("pre_reset_mask", 32'(o_mask), 32'h2);
    pulse_reset();
    check("midrun_reset", status(), 32'd0);
    tick();
    check("post_reset_idle", status(), 32'd0);
    gtab = 4'b1110;
    do_run("after_reset", 7, 4'b1110, 1'b0, 1'b0, 1'b0);

    // start held high retriggers one cycle after done
    do_run("held_start", 7, 4'b1110, 1'b0, 1'b0, 1'b1);
    pulse_reset();

    // Random gate tables with settle-time glitches on the default instance
    for (int r = 0; r < 5; r++) begin
      gtab = 4'($urandom);
      do_run("rand_a", 7, 4'b1110, 1'b1, 1'b0, 1'b0);
    end

    // SETTLE_CYCLES=1, XOR expectation, glitching XOR model
    sel  = 1;
    gtab = 4'b0110;
    do_run("xor_s1", 1, 4'b0110, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      gtab = 4'($urandom);
      do_run("rand_b", 1, 4'b0110, 1'b1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
